// File: rtl/dump_fsm.sv
// dump_fsm: output-side SHAKE control FSM draining squeezed rate blocks from the PISO as a valid/ready word stream
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   header_valid/header_ready     request handshake (ready is a same-cycle pulse)
//   output_length, mode           requested bits, 0=SHAKE128 1=SHAKE256
//   output_buffer_ready           PISO holds a fresh squeezed block
//   output_buffer_ready_clr       block drained pulse, qualified by last_output_block_wr
//   piso_shift_en                 advance PISO by one word
//   valid_out/ready_in            word stream handshake
//   last_out, last_word_bits      final-word marker and its valid bit count
//   done                          request complete pulse
module dump_fsm #(
    parameter int W             = 64,
    parameter int LEN_W         = 32,
    parameter int RATE128_WORDS = 21,
    parameter int RATE256_WORDS = 17,
    localparam int LB           = $clog2(W) + 1,
    localparam int CW           = $clog2(RATE128_WORDS > RATE256_WORDS ? RATE128_WORDS : RATE256_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             header_valid,
    output logic             header_ready,
    input  logic [LEN_W-1:0] output_length,
    input  logic             mode,
    input  logic             output_buffer_ready,
    output logic             output_buffer_ready_clr,
    output logic             last_output_block_wr,
    output logic             piso_shift_en,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             last_out,
    output logic [LB-1:0]    last_word_bits,
    output logic             done
);
    typedef enum logic [1:0] {WAIT_HEADER, WAIT_BLOCK, DUMP, DONE} state_t;
    state_t           state_q;
    logic [LEN_W-1:0] rem_q;
    logic [CW-1:0]    rate_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             hs;
    assign valid_out               = state_q == DUMP;
    assign hs                      = valid_out & ready_in;
    assign piso_shift_en           = hs;
    assign header_ready            = state_q == WAIT_HEADER && header_valid;
    // remaining_bits never reaches 0 inside DUMP, so the low bits hold the final word size
    assign last_out                = valid_out && rem_q <= LEN_W'(W);
    assign last_word_bits          = last_out ? rem_q[LB-1:0] : LB'(W);
    // last_out takes priority when the request ends exactly on a block boundary
    assign output_buffer_ready_clr = hs && (last_out || cnt_q == CW'(1));
    assign last_output_block_wr    = hs && last_out;
    assign done                    = done_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_HEADER;
            rem_q   <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                WAIT_HEADER: if (header_valid) begin
                    rem_q   <= output_length;
                    rate_q  <= mode ? CW'(RATE256_WORDS) : CW'(RATE128_WORDS);
                    state_q <= output_length == '0 ? DONE : WAIT_BLOCK;
                    done_q  <= output_length == '0;
                end
                WAIT_BLOCK: if (output_buffer_ready) begin
                    cnt_q   <= rate_q;
                    state_q <= DUMP;
                end
                DUMP: if (ready_in) begin
                    rem_q <= rem_q > LEN_W'(W) ? rem_q - LEN_W'(W) : '0;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_out) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (cnt_q == CW'(1)) begin
                        state_q <= WAIT_BLOCK;
                    end
                end
                default: if (!output_buffer_ready) state_q <= WAIT_HEADER;
            endcase
        end
    end
endmodule
